// File: rtl/tt_tbuf_arb_pkg.sv
// Shared state encoding and counter widths for the tristate-bus arbiter.
// Imported by the RTL and the testbench.
package tt_tbuf_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Sized for MAX_HOLD up to 255 and TURN_CYC up to 7.
  localparam int HOLD_W = 8;
  localparam int GAP_W  = 3;

endpackage

// File: rtl/tt_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after last+1, wrapping mod N.
module tt_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] index
);

  // Scan from the farthest offset down so the nearest requester overwrites the rest.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        valid = 1'b1;
        index = IW'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/tt_tbuf_arb.sv
// Tristate-net ownership arbiter: round-robin grant, bounded hold under contention,
// and an all-Hi-Z turnaround gap between successive drivers.
module tt_tbuf_arb
  import tt_tbuf_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int TURN_CYC = 1,
  parameter  int MAX_HOLD = 16,
  localparam int IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  tx,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] owner,
  output logic          busy
);

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold, hold_nxt;
  logic [GAP_W-1:0]    gap_cnt, gap_nxt;
  logic [IW-1:0]       last_owner, last_nxt;
  logic [N-1:0]        grant_nxt;
  logic [IW-1:0]       owner_nxt;
  logic                busy_nxt;
  logic                pick_valid;
  logic [IW-1:0]       pick_idx;
  logic                release_req, preempt;

  tt_rr_pick #(.N(N)) u_pick (
    .req   (req),
    .last  (last_owner),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign release_req = ~req[owner];
  assign preempt     = (hold == HOLD_W'(MAX_HOLD)) && (|(req & ~grant));

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    gap_nxt   = gap_cnt;
    last_nxt  = last_owner;
    grant_nxt = grant;
    owner_nxt = owner;
    unique case (state)
      ST_IDLE: begin
        grant_nxt = '0;
        owner_nxt = '0;
        if (pick_valid) begin
          state_nxt           = ST_DRIVE;
          grant_nxt[pick_idx] = 1'b1;
          owner_nxt           = pick_idx;
          hold_nxt            = HOLD_W'(1);
        end
      end
      ST_DRIVE: begin
        // Release and preemption collapse into the same single exit.
        if (release_req || preempt) begin
          state_nxt = ST_GAP;
          last_nxt  = owner;
          grant_nxt = '0;
          owner_nxt = '0;
          hold_nxt  = '0;
          gap_nxt   = GAP_W'(1);
        end else if (hold != HOLD_W'(MAX_HOLD)) begin
          hold_nxt = hold + HOLD_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(TURN_CYC)) begin
          state_nxt = ST_IDLE;
          gap_nxt   = '0;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        owner_nxt = '0;
        hold_nxt  = '0;
        gap_nxt   = '0;
      end
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // Registered outputs: tx is a separate flop so it never glitches against grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      hold       <= '0;
      gap_cnt    <= '0;
      last_owner <= IW'(N - 1);
      grant      <= '0;
      owner      <= '0;
      busy       <= 1'b0;
      tx         <= '1;
    end else begin
      state      <= state_nxt;
      hold       <= hold_nxt;
      gap_cnt    <= gap_nxt;
      last_owner <= last_nxt;
      grant      <= grant_nxt;
      owner      <= owner_nxt;
      busy       <= busy_nxt;
      tx         <= ~grant_nxt;
    end
  end

endmodule

// File: tb/tb_tt_tbuf_arb.sv
// Scoreboard bench for tt_tbuf_arb (N=4, TURN_CYC=2, MAX_HOLD=4): directed vectors
// with hand-derived expectations, plus per-cycle bus-safety invariants under random req.
module tb_tt_tbuf_arb;
  import tt_tbuf_arb_pkg::*;

  localparam int N        = 4;
  localparam int TURN_CYC = 2;
  localparam int MAX_HOLD = 4;

  typedef struct {
    logic [3:0] g;
    logic [1:0] o;
    logic       b;
    int         id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] tx;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   vid   = 0;

  tt_tbuf_arb #(.N(N), .TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .tx    (tx),
    .grant (grant),
    .owner (owner),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic [3:0] rq,
                      input logic [3:0] g, input logic [1:0] o, input logic b);
    @(negedge clk);
    rst = r;
    req = rq;
    exp_q.push_back('{g: g, o: o, b: b, id: vid});
    vid++;
  endtask

  task automatic idle_after_reset();
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
  endtask

  // Monitor: scoreboard pops plus bus-safety invariants every cycle.
  initial begin
    exp_t e;
    logic       saw_reset = 1'b0;
    logic       had_drv   = 1'b0;
    int         hiz       = 0;
    logic [3:0] prev_g    = 4'b0000;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (grant !== e.g || owner !== e.o || busy !== e.b || tx !== ~e.g) begin
          n_bad++;
          $display("FAIL vec%0d grant/owner/busy/tx got=%b/%0d/%b/%b want=%b/%0d/%b/%b",
                   e.id, grant, owner, busy, tx, e.g, e.o, e.b, ~e.g);
        end
      end
      if (rst) saw_reset = 1'b1;
      if (saw_reset) begin
        if ($countones(~tx) > 1) begin
          n_bad++;
          $display("FAIL onehot_tx got=%b want=at_most_one_zero", tx);
        end
        if (tx !== ~grant) begin
          n_bad++;
          $display("FAIL tx_vs_grant got=%b want=%b", tx, ~grant);
        end
        if (rst) begin
          had_drv = 1'b0;
          hiz     = 0;
        end else if (grant != 4'b0000) begin
          if (prev_g != 4'b0000 && grant != prev_g) begin
            n_bad++;
            $display("FAIL direct_handover got=%b want=%b", grant, prev_g);
          end
          if (prev_g == 4'b0000 && had_drv && hiz < TURN_CYC) begin
            n_bad++;
            $display("FAIL turnaround got=%0d want>=%0d", hiz, TURN_CYC);
          end
          had_drv = 1'b1;
          hiz     = 0;
        end else begin
          hiz++;
        end
        prev_g = grant;
      end
    end
  end

  initial begin
    // Single grant, release with a pending requester, and the turnaround timing.
    idle_after_reset();
    step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1);
    step(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1);
    step(1'b0, 4'b0100, 4'b0000, 2'd0, 1'b1);
    step(1'b0, 4'b0100, 4'b0000, 2'd0, 1'b1);
    step(1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1);
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1);
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // All requesting: rotation 0,1,2,3,0 with 4 drive, 2 gap, 1 idle cycles.
    idle_after_reset();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++)
        step(1'b0, 4'b1111, 4'(1 << (r % 4)), 2'(r % 4), 1'b1);
      if (r < 4) begin
        step(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b1);
        step(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b1);
        step(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0);
      end
    end

    // Lone requester keeps the bus; a late competitor preempts at once (hold saturated).
    idle_after_reset();
    for (int c = 0; c < 100; c++)
      step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1);
    step(1'b0, 4'b0011, 4'b0000, 2'd0, 1'b1);
    step(1'b0, 4'b0011, 4'b0000, 2'd0, 1'b1);
    step(1'b0, 4'b0011, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1);

    // Release coinciding with preemption gives one gap; req during the gap is ignored.
    idle_after_reset();
    step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1);
    step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1);
    step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1);
    step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1);
    step(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b1);
    step(1'b0, 4'b1000, 4'b0000, 2'd0, 1'b1);
    step(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1);

    // Reset mid-drive tristates immediately; requester 0 wins straight afterwards.
    idle_after_reset();
    step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1);
    step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1);
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1);

    // Random traffic, checked by the invariants only.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = 1'b0;
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_tbuf_arb.md
TT_TBUF_ARB -- requirements
Module: tt_tbuf_arb

Interface
REQ-001 Parameter N, default 4: number of requesters sharing one tristate net, range 2..8.
REQ-002 Parameter TURN_CYC, default 1: all-off turnaround cycles between drivers, range 1..7.
REQ-003 Parameter MAX_HOLD, default 16: maximum DRIVE cycles while another request is pending, range 2..255.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  N  per-requester bus request, level-held until done.
REQ-007 tx  output  N  per-requester tristate-buffer enable, active-low (0 = drive, 1 = Hi-Z); connects directly to TE_B of each buffer.
REQ-008 grant  output  N  one-hot: current owner is driving this cycle.
REQ-009 owner  output  clog2(N)  index of current owner; 0 when no owner.
REQ-010 busy  output  1  high in DRIVE or GAP.

Function
REQ-011 Three states: IDLE (no driver), DRIVE (one driver), GAP (turnaround, no driver).
REQ-012 All outputs are registered; tx equals ~grant on every cycle.
REQ-013 At most one tx bit is 0 in any cycle, including reset, state change and parameter extremes.
REQ-014 IDLE: on an edge where any req is 1, select a winner round-robin starting at last_owner+1 mod N; enter DRIVE; grant[w]=1 and tx[w]=0 from that edge (1-cycle latency).
REQ-015 IDLE with req all 0: stay IDLE; outputs tx all 1, grant 0, owner 0, busy 0.
REQ-016 DRIVE: hold counter increments each cycle, saturating at MAX_HOLD.
REQ-017 DRIVE to GAP on the first edge where req[owner]=0 (release).
REQ-018 DRIVE to GAP when the hold counter reaches MAX_HOLD and any other req bit is 1 (preemption); with no competitor, ownership persists indefinitely.
REQ-019 On DRIVE exit, last_owner <= owner; grant and tx release on the same edge.
REQ-020 GAP lasts exactly TURN_CYC cycles with tx all 1, busy 1, then IDLE; a new driver therefore appears no earlier than TURN_CYC+1 cycles after release.
REQ-021 Simultaneous release and preemption condition: treated as one transition to GAP.
REQ-022 A preempted owner still requesting competes normally in the next arbitration; round-robin guarantees every other pending requester is served first.
REQ-023 req changes during GAP are ignored until IDLE.

Reset
REQ-024 rst=1 forces IDLE, tx all 1, grant 0, owner 0, busy 0, hold counter 0, GAP counter 0, last_owner N-1 (requester 0 has first priority) on that edge.
REQ-025 Reset asserted mid-DRIVE tristates all buffers on the same edge; no turnaround is inserted afterwards.

Structure
REQ-026 State encoding (IDLE=0, DRIVE=1, GAP=2) and counter width constants reside in the shared header tt_tbuf_arb_defs, included by the RTL and the bench.
REQ-027 The round-robin picker is a separate combinational sub-module tt_rr_pick (inputs: req, last; outputs: valid, index), reusable elsewhere in the multiplexer.
REQ-028 The block does not instantiate the tristate buffers; the top level wires tx[i] to buffer i.

Verification
REQ-029 N=4, TURN_CYC=2: reset, req=0001 -> after 1 edge tx=1110, grant=0001, owner=0, busy=1.
REQ-030 Owner 0 drops req, req=0100 pending -> tx=1111 for exactly 2 cycles, then 1 IDLE cycle, then tx=1011, owner=2.
REQ-031 req=1111 held, MAX_HOLD=4 -> owners rotate 0,1,2,3,0, each exactly 4 DRIVE cycles, separated by 2 GAP and 1 IDLE cycles.
REQ-032 req=0010 alone held for 100 cycles, MAX_HOLD=4 -> owner stays 1, no GAP.
REQ-033 rst pulsed mid-DRIVE with req=1111 -> tx=1111 same edge; the next grant after rst falls goes to requester 0.
REQ-034 Random req for 10k cycles, all parameter corners -> assertion: popcount(~tx)<=1, tx==~grant, and no owner change without at least TURN_CYC all-Hi-Z cycles.
